// File: rtl/serial_bus_master_if.sv
// rtl/serial_bus_master_if.sv - request/response handshake and serial bus wires of the bus master
interface serial_bus_master_if #(
  parameter int N   = 8,
  parameter int ADN = 12
);
  logic           req_valid;
  logic           req_wren;
  logic [ADN-1:0] req_addr;
  logic [N-1:0]   req_wdata;
  logic           req_ready;
  logic           rsp_valid;
  logic           rsp_err;
  logic [N-1:0]   rsp_rdata;
  logic           bus_valid;
  logic           bus_wren;
  logic           bus_addr;
  logic           bus_wdata;
  logic           bus_rvalid;
  logic           bus_rdata;

  modport master (
    input  req_valid, req_wren, req_addr, req_wdata, bus_rvalid, bus_rdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
    output bus_valid, bus_wren, bus_addr, bus_wdata
  );

  modport slave (
    output req_valid, req_wren, req_addr, req_wdata, bus_rvalid, bus_rdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
    input  bus_valid, bus_wren, bus_addr, bus_wdata
  );
endinterface

// File: rtl/serial_bus_master.sv
// rtl/serial_bus_master.sv - serial memory bus initiator: serialises requests, deserialises reads
module serial_bus_master #(
  parameter int N       = 8,
  parameter int ADN     = 12,
  parameter int TIMEOUT = 64
) (
  input logic                clk,
  input logic                rst,
  serial_bus_master_if.master sb
);
  localparam int KW = $clog2(ADN) + 1;
  localparam int RW = $clog2(N) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, HDR, ADDR, WGAP, RWAIT, RDATA} state_t;

  state_t         state;
  logic [KW-1:0]  bitCnt;
  logic [RW-1:0]  rdCnt;
  logic [TW-1:0]  tmoCnt;
  logic [ADN-1:0] addrSh;
  logic [N-1:0]   wdataSh;
  logic [N-1:0]   rdSh;
  logic           wrenReg;
  logic           busValid, busWren, busAddr, busWdata;
  logic           rspValid, rspErr;
  logic [N-1:0]   rspRdata;

  // Data bits ride alongside the last N address bits of a write.
  function automatic logic emitW(input logic wr, input logic [KW-1:0] k);
    return wr && (k >= KW'(ADN - N));
  endfunction

  assign sb.req_ready = (state == IDLE) && !rst;
  assign sb.bus_valid = busValid;
  assign sb.bus_wren  = busWren;
  assign sb.bus_addr  = busAddr;
  assign sb.bus_wdata = busWdata;
  assign sb.rsp_valid = rspValid;
  assign sb.rsp_err   = rspErr;
  assign sb.rsp_rdata = rspRdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bitCnt   <= '0;
      rdCnt    <= '0;
      tmoCnt   <= '0;
      addrSh   <= '0;
      wdataSh  <= '0;
      rdSh     <= '0;
      wrenReg  <= 1'b0;
      busValid <= 1'b0;
      busWren  <= 1'b0;
      busAddr  <= 1'b0;
      busWdata <= 1'b0;
      rspValid <= 1'b0;
      rspErr   <= 1'b0;
      rspRdata <= '0;
    end else begin
      rspValid <= 1'b0;
      case (state)
        IDLE: begin
          if (sb.req_valid) begin
            state    <= HDR;
            addrSh   <= sb.req_addr;
            wdataSh  <= sb.req_wdata;
            wrenReg  <= sb.req_wren;
            busValid <= 1'b1;
            busWren  <= sb.req_wren;
            busAddr  <= 1'b0;
            busWdata <= 1'b0;
          end
        end
        HDR: begin
          state   <= ADDR;
          bitCnt  <= '0;
          busAddr <= addrSh[ADN-1];
          addrSh  <= addrSh << 1;
          if (emitW(wrenReg, '0)) begin
            busWdata <= wdataSh[N-1];
            wdataSh  <= wdataSh << 1;
          end else begin
            busWdata <= 1'b0;
          end
        end
        ADDR: begin
          if (bitCnt == KW'(ADN - 1)) begin
            busValid <= 1'b0;
            busAddr  <= 1'b0;
            busWdata <= 1'b0;
            bitCnt   <= '0;
            tmoCnt   <= '0;
            state    <= wrenReg ? WGAP : RWAIT;
          end else begin
            bitCnt  <= bitCnt + KW'(1);
            busAddr <= addrSh[ADN-1];
            addrSh  <= addrSh << 1;
            if (emitW(wrenReg, bitCnt + KW'(1))) begin
              busWdata <= wdataSh[N-1];
              wdataSh  <= wdataSh << 1;
            end else begin
              busWdata <= 1'b0;
            end
          end
        end
        WGAP: begin
          if (bitCnt == KW'(1)) begin
            state    <= IDLE;
            busWren  <= 1'b0;
            rspValid <= 1'b1;
            rspErr   <= 1'b0;
            rspRdata <= '0;
          end else begin
            bitCnt <= bitCnt + KW'(1);
          end
        end
        RWAIT: begin
          // The first valid cycle from the slave is a preamble; its data bit is dropped.
          if (sb.bus_rvalid) begin
            state <= RDATA;
            rdCnt <= '0;
            rdSh  <= '0;
          end else if (tmoCnt == TW'(TIMEOUT - 1)) begin
            state    <= IDLE;
            rspValid <= 1'b1;
            rspErr   <= 1'b1;
            rspRdata <= '0;
          end else begin
            tmoCnt <= tmoCnt + TW'(1);
          end
        end
        RDATA: begin
          if (!sb.bus_rvalid) begin
            state    <= IDLE;
            rspValid <= 1'b1;
            rspErr   <= 1'b1;
            rspRdata <= '0;
          end else if (rdCnt == RW'(N - 1)) begin
            state    <= IDLE;
            rdSh     <= {rdSh[N-2:0], sb.bus_rdata};
            rspValid <= 1'b1;
            rspErr   <= 1'b0;
            rspRdata <= {rdSh[N-2:0], sb.bus_rdata};
          end else begin
            rdSh  <= {rdSh[N-2:0], sb.bus_rdata};
            rdCnt <= rdCnt + RW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_bus_master.sv
// tb/tb_serial_bus_master.sv - directed bench with response scoreboard and behavioural bus slave memory
module tb_serial_bus_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_bus_master_if #(.N(8), .ADN(12)) sb();

  serial_bus_master #(.N(8), .ADN(12), .TIMEOUT(64)) dut (
    .clk(clk),
    .rst(rst),
    .sb (sb)
  );

  int nCmp = 0;
  int nBad = 0;
  logic [8:0] expQ[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural slave memory
  logic [7:0]  mem [0:4095];
  logic [11:0] sAddr;
  logic [11:0] lastWrAddr = '0;
  logic [7:0]  sData, rdShift;
  logic        sWren;
  int          sState = 0;
  int          sCnt = 0;
  logic        slaveMute = 1'b0;
  logic        slaveBreak = 1'b0;
  logic        forceEn = 1'b0;
  logic [7:0]  forceData = '0;

  always @(negedge clk) begin
    if (rst) begin
      sState = 0;
      sb.bus_rvalid = 1'b0;
      sb.bus_rdata  = 1'b0;
    end else begin
      sb.bus_rvalid = 1'b0;
      sb.bus_rdata  = 1'b0;
      case (sState)
        0: if (sb.bus_valid) begin sWren = sb.bus_wren; sState = 1; end
        1: begin
          if (sb.bus_valid) begin
            sAddr = {sAddr[10:0], sb.bus_addr};
            sData = {sData[6:0], sb.bus_wdata};
          end else if (sWren) begin
            mem[sAddr] = sData;
            lastWrAddr = sAddr;
            sState = 0;
          end else if (slaveMute) begin
            sState = 0;
          end else begin
            sState = 2;
            sCnt = 0;
          end
        end
        2: begin
          sCnt++;
          if (sCnt == 3) begin
            sb.bus_rvalid = 1'b1;
            sb.bus_rdata  = 1'b1;
            rdShift = forceEn ? forceData : mem[sAddr];
            sCnt = 0;
            sState = 3;
          end
        end
        default: begin
          sb.bus_rvalid = !(slaveBreak && sCnt == 4);
          sb.bus_rdata  = rdShift[7];
          rdShift = {rdShift[6:0], 1'b0};
          sCnt++;
          if (sCnt == 8) sState = 0;
        end
      endcase
    end
  end

  // Scoreboard: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && sb.rsp_valid) begin
      logic [8:0] e;
      check("rsp_expected", (expQ.size() != 0), 1);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        check("rsp_err", sb.rsp_err, e[8]);
        check("rsp_rdata", sb.rsp_rdata, e[7:0]);
      end
    end
  end

  int lat, capValid;
  logic [11:0] capAddr, capData;
  logic capWrenOr, capWrenLast;

  task automatic runReq(input logic wren, input logic [11:0] addr, input logic [7:0] wdata,
                        input logic expErr, input logic [7:0] expData);
    int n = 0;
    while (!sb.req_ready && n < 200) begin @(negedge clk); n++; end
    check("req_ready_before", sb.req_ready, 1);
    sb.req_valid = 1'b1;
    sb.req_wren  = wren;
    sb.req_addr  = addr;
    sb.req_wdata = wdata;
    expQ.push_back({expErr, expData});
    @(negedge clk);
    sb.req_valid = 1'b0;
    lat = 1; capValid = 0; capAddr = '0; capData = '0; capWrenOr = 1'b0; capWrenLast = 1'b0;
    while (!sb.rsp_valid && lat < 300) begin
      if (sb.bus_valid) begin
        capValid++;
        capAddr = {capAddr[10:0], sb.bus_addr};
        capData = {capData[10:0], sb.bus_wdata};
      end
      capWrenOr   = capWrenOr | sb.bus_wren;
      capWrenLast = sb.bus_wren;
      @(negedge clk);
      lat++;
    end
    check("rsp_arrived", sb.rsp_valid, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    logic busyReady;
    sb.req_valid = 1'b0; sb.req_wren = 1'b0; sb.req_addr = '0; sb.req_wdata = '0;
    repeat (2) @(negedge clk);
    check("reset_req_ready", sb.req_ready, 0);
    check("reset_bus_valid", sb.bus_valid, 0);
    check("reset_rsp_valid", sb.rsp_valid, 0);
    check("reset_rsp_rdata", sb.rsp_rdata, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", sb.req_ready, 1);

    // Write 0x3C to 0xA5C
    runReq(1'b1, 12'hA5C, 8'h3C, 1'b0, 8'h00);
    check("wr_latency", lat, 16);
    check("wr_valid_cycles", capValid, 13);
    check("wr_addr_bits", capAddr, 12'hA5C);
    check("wr_wdata_bits", capData, 12'h03C);
    check("wr_gap_wren", capWrenLast, 1);

    // Read 0x012, slave forced to return 0x96
    forceEn = 1'b1; forceData = 8'h96;
    runReq(1'b0, 12'h012, 8'hFF, 1'b0, 8'h96);
    check("rd_wren_low", capWrenOr, 0);
    check("rd_latency", lat, 26);
    check("rd_addr_bits", capAddr, 12'h012);
    check("rd_wdata_zero", capData, 12'h000);
    forceEn = 1'b0;

    // Busy write with a second request held pending
    n = 0;
    while (!sb.req_ready && n < 200) begin @(negedge clk); n++; end
    sb.req_valid = 1'b1; sb.req_wren = 1'b1; sb.req_addr = 12'h123; sb.req_wdata = 8'h11;
    expQ.push_back(9'h000);
    @(negedge clk);
    sb.req_addr = 12'h7FF; sb.req_wdata = 8'h5A;
    expQ.push_back(9'h000);
    busyReady = 1'b0; n = 1;
    while (!sb.rsp_valid && n < 300) begin
      busyReady = busyReady | sb.req_ready;
      @(negedge clk);
      n++;
    end
    check("busy_req_ready", busyReady, 0);
    check("busy_latency", n, 16);
    check("rsp_cycle_ready", sb.req_ready, 1);
    check("busy_first_addr", lastWrAddr, 12'h123);
    @(negedge clk);
    sb.req_valid = 1'b0;
    check("second_hdr_valid", sb.bus_valid, 1);
    check("second_hdr_wren", sb.bus_wren, 1);
    n = 1;
    while (!sb.rsp_valid && n < 300) begin @(negedge clk); n++; end
    check("second_latency", n, 16);
    check("second_wr_addr", lastWrAddr, 12'h7FF);

    // Read back through the memory model
    runReq(1'b0, 12'h7FF, 8'h00, 1'b0, 8'h5A);

    // Silent slave: timeout, then the master takes a new request
    slaveMute = 1'b1;
    runReq(1'b0, 12'h100, 8'h00, 1'b1, 8'h00);
    check("timeout_latency", lat, 78);
    slaveMute = 1'b0;
    runReq(1'b1, 12'h200, 8'h77, 1'b0, 8'h00);
    check("post_timeout_wr_latency", lat, 16);

    // Slave drops validOut mid-word
    slaveBreak = 1'b1;
    runReq(1'b0, 12'h200, 8'h00, 1'b1, 8'h00);
    check("broken_latency", lat, 23);
    slaveBreak = 1'b0;
    repeat (10) @(negedge clk);
    runReq(1'b0, 12'h200, 8'h00, 1'b0, 8'h77);

    // Reset during address bit 5 of a read
    sb.req_valid = 1'b1; sb.req_wren = 1'b0; sb.req_addr = 12'h0F0; sb.req_wdata = 8'h00;
    @(negedge clk);
    sb.req_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_pre_valid", sb.bus_valid, 1);
    rst = 1'b1;
    #1;
    check("abort_bus_valid", sb.bus_valid, 0);
    check("abort_req_ready", sb.req_ready, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_idle_ready", sb.req_ready, 1);
    runReq(1'b1, 12'h345, 8'hC3, 1'b0, 8'h00);
    check("abort_wr_latency", lat, 16);
    runReq(1'b0, 12'h345, 8'h00, 1'b0, 8'hC3);
    @(negedge clk);
    check("hold_rsp_valid", sb.rsp_valid, 0);
    check("hold_rsp_rdata", sb.rsp_rdata, 8'hC3);

    repeat (5) @(negedge clk);
    check("queue_empty", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
